// File: rtl/ex_div_if.sv
// ex_div_if -- EX-stage <-> divider handshake bundle.
//   master : EX stage (drives div_start/div_signed/opdata1/opdata2/annul)
//   slave  : divider  (drives result/ready/stall_req/div_zero)
//   result = {remainder, quotient}; stall_req is combinational.
interface ex_div_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;
  logic        div_zero;

  modport master (
    output div_start, div_signed, opdata1, opdata2, annul,
    input  result, ready, stall_req, div_zero
  );

  modport slave (
    input  div_start, div_signed, opdata1, opdata2, annul,
    output result, ready, stall_req, div_zero
  );
endinterface

// File: rtl/ex_div.sv
// ex_div -- 32-bit multi-cycle radix-2 restoring divider for the EX stage.
//   clk   : rising-edge clock
//   rst   : async active-low reset
//   bus   : ex_div_if.slave (start/signed/operands/annul in,
//           result/ready/div_zero registered out, stall_req combinational)
// Latency: 33 cycles from the edge that samples div_start in IDLE to ready.
// Build option: define EX_DIV_ZERO_FLAG_EN to short-circuit a zero divisor
// straight to DONE with result={dividend, 32'hFFFFFFFF} and div_zero=1.
module ex_div (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_work;      // {partial remainder, dividend/quotient}
  logic [31:0] r_divisor;   // magnitude of divisor
  logic        r_neg_q;     // quotient needs negating
  logic        r_neg_r;     // remainder takes dividend's (negative) sign
  logic [63:0] r_result;
  logic        r_ready;
  logic        r_div_zero;

  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_abs, w_b_abs;
  logic [32:0] w_trial;
  logic [63:0] w_next_work;
  logic [31:0] w_quo, w_rem;
  logic        w_zero_fast;

  assign w_a_neg = bus.div_signed & bus.opdata1[31];
  assign w_b_neg = bus.div_signed & bus.opdata2[31];
  // 0x80000000 maps onto itself, which is the right magnitude mod 2^32.
  assign w_a_abs = w_a_neg ? (~bus.opdata1 + 32'd1) : bus.opdata1;
  assign w_b_abs = w_b_neg ? (~bus.opdata2 + 32'd1) : bus.opdata2;

  // r_work[63] is the bit shifted out of the remainder, so compare with 33 bits.
  assign w_trial     = r_work[63:31] - {1'b0, r_divisor};
  assign w_next_work = w_trial[32] ? {r_work[62:0], 1'b0}
                                   : {w_trial[31:0], r_work[30:0], 1'b1};

  assign w_quo = r_neg_q ? (~r_work[31:0]  + 32'd1) : r_work[31:0];
  assign w_rem = r_neg_r ? (~r_work[63:32] + 32'd1) : r_work[63:32];

`ifdef EX_DIV_ZERO_FLAG_EN
  assign w_zero_fast = (bus.opdata2 == 32'd0);
`else
  assign w_zero_fast = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 6'd0;
      r_work     <= 64'd0;
      r_divisor  <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= 64'd0;
      r_ready    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.div_start && !bus.annul) begin
            if (w_zero_fast) begin
              r_result   <= {bus.opdata1, 32'hFFFF_FFFF};
              r_ready    <= 1'b1;
              r_div_zero <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_work    <= {32'd0, w_a_abs};
              r_divisor <= w_b_abs;
              r_neg_q   <= w_a_neg ^ w_b_neg;
              r_neg_r   <= w_a_neg;
              r_cnt     <= 6'd0;
              r_state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.annul) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
          end else if (r_cnt == 6'd32) begin
            // All 32 steps done: apply sign fixup and publish.
            r_result <= {w_rem, w_quo};
            r_ready  <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_work <= w_next_work;
            r_cnt  <= r_cnt + 6'd1;
          end
        end
        DONE: begin
          if (bus.annul || !bus.div_start) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_div_zero <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.result    = r_result;
  assign bus.ready     = r_ready;
  assign bus.div_zero  = r_div_zero;
  assign bus.stall_req = ((r_state == IDLE) && bus.div_start && !bus.annul)
                       || (r_state == BUSY);

endmodule
